// File: rtl/stage_mem_pkg.sv
// stage_mem_pkg: shared definitions for the memory-access stage.
//   - funct3 encodings for loads (LB..LHU) and stores (SB/SH/SW)
//   - FSM state type (IDLE/BUSY)
package stage_mem_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

endpackage

// File: rtl/stage_mem_if.sv
// stage_mem_if: Wishbone-classic data-bus bundle between the memory stage
// (master) and the data memory / interconnect (slave).
//   dwbm_addr_o  word address (low 2 bits always 0)
//   dwbm_dat_o   write data          dwbm_dat_i  read data
//   dwbm_sel_o   byte enables        dwbm_we_o   write enable
//   dwbm_cyc_o   cycle               dwbm_stb_o  strobe
//   dwbm_ack_i   acknowledge         dwbm_err_i  bus error
interface stage_mem_if #(
   parameter int ADDR_W = 32
) ();
   logic [ADDR_W-1:0] dwbm_addr_o;
   logic [31:0]       dwbm_dat_o;
   logic [3:0]        dwbm_sel_o;
   logic              dwbm_cyc_o;
   logic              dwbm_stb_o;
   logic              dwbm_we_o;
   logic [31:0]       dwbm_dat_i;
   logic              dwbm_ack_i;
   logic              dwbm_err_i;

   modport master (
      output dwbm_addr_o, dwbm_dat_o, dwbm_sel_o, dwbm_cyc_o, dwbm_stb_o, dwbm_we_o,
      input  dwbm_dat_i, dwbm_ack_i, dwbm_err_i
   );

   modport slave (
      input  dwbm_addr_o, dwbm_dat_o, dwbm_sel_o, dwbm_cyc_o, dwbm_stb_o, dwbm_we_o,
      output dwbm_dat_i, dwbm_ack_i, dwbm_err_i
   );
endinterface

// File: rtl/stage_mem_align.sv
// stage_mem_align: purely combinational data alignment for the memory stage.
//   i_funct3  access size/sign     i_lane    byte offset (addr[1:0])
//   i_st_dat  raw store data       i_rd_dat  raw bus read word
//   o_sel     byte enables         o_st_dat  lane-replicated store data
//   o_ld_dat  extracted/extended load data
//   o_mis     access is misaligned for its size
module stage_mem_align
   import stage_mem_pkg::*;
(
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_lane,
   input  logic [31:0] i_st_dat,
   input  logic [31:0] i_rd_dat,
   output logic [3:0]  o_sel,
   output logic [31:0] o_st_dat,
   output logic [31:0] o_ld_dat,
   output logic        o_mis
);
   logic        w_is_word;
   logic        w_is_half;
   logic [31:0] w_shift;

   // funct3[1] set means word (011/11x fold into word as well)
   assign w_is_word = i_funct3[1];
   assign w_is_half = !i_funct3[1] && i_funct3[0];

   // Bring the addressed lane down to bit 0 before extending
   assign w_shift = i_rd_dat >> {i_lane, 3'b000};

   always_comb begin
      o_mis    = 1'b0;
      o_sel    = 4'b0001 << i_lane;
      o_st_dat = {4{i_st_dat[7:0]}};
      if (w_is_word) begin
         o_mis    = (i_lane != 2'b00);
         o_sel    = 4'b1111;
         o_st_dat = i_st_dat;
      end else if (w_is_half) begin
         o_mis    = i_lane[0];
         o_sel    = 4'b0011 << {i_lane[1], 1'b0};
         o_st_dat = {2{i_st_dat[15:0]}};
      end
   end

   always_comb begin
      o_ld_dat = i_rd_dat;
      case (i_funct3)
         F3_LB:   o_ld_dat = {{24{w_shift[7]}}, w_shift[7:0]};
         F3_LH:   o_ld_dat = {{16{w_shift[15]}}, w_shift[15:0]};
         F3_LBU:  o_ld_dat = {24'h0, w_shift[7:0]};
         F3_LHU:  o_ld_dat = {16'h0, w_shift[15:0]};
         default: o_ld_dat = i_rd_dat;
      endcase
   end
endmodule

// File: rtl/stage_mem.sv
// stage_mem: pipeline memory-access stage. Issues one Wishbone-classic
// transaction per aligned load/store, stalls until ack/err/timeout,
// returns formatted load data and flags misalignment / access faults.
//   clk_i, rst_i        clock, synchronous active-high reset
//   valid_i, kill_i     instruction valid, flush of a not-yet-issued access
//   alu_out_i           effective address
//   dat_b_i, funct3_i   store data, access size/sign
//   is_ld_inst_i/is_st_inst_i  load / store (store wins if both)
//   stall_o, ld_dat_o   pipeline hold, load result
//   e_*_o               misaligned load/store, access fault pulse
//   dwbm                Wishbone master bundle
module stage_mem
   import stage_mem_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 0
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        valid_i,
   input  logic        kill_i,
   input  logic [31:0] alu_out_i,
   input  logic [31:0] dat_b_i,
   input  logic [2:0]  funct3_i,
   input  logic        is_ld_inst_i,
   input  logic        is_st_inst_i,
   output logic        stall_o,
   output logic [31:0] ld_dat_o,
   output logic        e_ld_addr_mis_o,
   output logic        e_st_addr_mis_o,
   output logic        e_access_fault_o,
   stage_mem_if.master dwbm
);
   state_t            r_state;
   state_t            w_state_next;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdat;
   logic [3:0]        r_sel;
   logic              r_we;
   logic [2:0]        r_funct3;
   logic [1:0]        r_lane;
   logic [31:0]       r_ld_dat;
   logic [31:0]       r_tcnt;

   logic        w_busy;
   logic        w_req;
   logic        w_mis;
   logic        w_issue;
   logic        w_timeout;
   logic        w_fault;
   logic        w_done;
   logic        w_ld_ack;
   logic [2:0]  w_funct3;
   logic [1:0]  w_lane;
   logic [3:0]  w_sel;
   logic [31:0] w_st_dat;
   logic [31:0] w_fmt;

   assign w_busy = (r_state == BUSY);
   assign w_req  = valid_i && !kill_i && (is_ld_inst_i || is_st_inst_i);

   // One aligner serves both phases: live inputs while deciding to issue,
   // captured size/lane while the access is in flight (the live inputs may
   // belong to a stalled but unrelated view of the pipe by then).
   assign w_funct3 = w_busy ? r_funct3 : funct3_i;
   assign w_lane   = w_busy ? r_lane   : alu_out_i[1:0];

   stage_mem_align u_align (
      .i_funct3 (w_funct3),
      .i_lane   (w_lane),
      .i_st_dat (dat_b_i),
      .i_rd_dat (dwbm.dwbm_dat_i),
      .o_sel    (w_sel),
      .o_st_dat (w_st_dat),
      .o_ld_dat (w_fmt),
      .o_mis    (w_mis)
   );

   // Counter saturates at TIMEOUT, so the fault fires after TIMEOUT full
   // BUSY cycles without a response.
   assign w_timeout = (TIMEOUT != 0) && w_busy && (r_tcnt == 32'(TIMEOUT));
   // err beats ack when both arrive together
   assign w_fault   = w_busy && (dwbm.dwbm_err_i || w_timeout);
   assign w_done    = w_busy && (dwbm.dwbm_ack_i || dwbm.dwbm_err_i || w_timeout);
   assign w_ld_ack  = w_busy && dwbm.dwbm_ack_i && !w_fault && !r_we;

   always_comb begin
      w_state_next = r_state;
      w_issue      = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_req && !w_mis) begin
               w_state_next = BUSY;
               w_issue      = 1'b1;
            end
         end
         BUSY: begin
            if (w_done) w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_addr   <= '0;
         r_wdat   <= '0;
         r_sel    <= '0;
         r_we     <= 1'b0;
         r_funct3 <= '0;
         r_lane   <= '0;
         r_ld_dat <= '0;
         r_tcnt   <= '0;
      end else begin
         if (w_issue) begin
            r_addr   <= {alu_out_i[ADDR_W-1:2], 2'b00};
            r_wdat   <= w_st_dat;
            r_sel    <= w_sel;
            r_we     <= is_st_inst_i;
            r_funct3 <= funct3_i;
            r_lane   <= alu_out_i[1:0];
            r_tcnt   <= '0;
         end else if (w_busy && (r_tcnt != 32'(TIMEOUT))) begin
            r_tcnt <= r_tcnt + 32'd1;
         end
         if (w_ld_ack) r_ld_dat <= w_fmt;
      end
   end

   assign stall_o          = w_issue || (w_busy && !w_done);
   assign ld_dat_o         = w_ld_ack ? w_fmt : r_ld_dat;
   assign e_ld_addr_mis_o  = w_req && is_ld_inst_i && w_mis;
   assign e_st_addr_mis_o  = w_req && is_st_inst_i && w_mis;
   assign e_access_fault_o = w_fault;

   assign dwbm.dwbm_addr_o = r_addr;
   assign dwbm.dwbm_dat_o  = r_wdat;
   assign dwbm.dwbm_sel_o  = r_sel;
   assign dwbm.dwbm_cyc_o  = w_busy;
   assign dwbm.dwbm_stb_o  = w_busy;
   assign dwbm.dwbm_we_o   = w_busy && r_we;
endmodule
